// File: rtl/bitstream_to_binary.sv
// bitstream_to_binary
//   Converts a stochastic unipolar bitstream into an unsigned binary
//   probability. It counts the ones over a window of 2**WIDTH samples and
//   saturates the result to 2**WIDTH-1. An optional settle period first
//   discards early bits while the upstream stage reaches steady state. The
//   result is held behind a valid/ready handshake.
//
// Parameters
//   WIDTH       result width; the count window is 2**WIDTH cycles
//   SETTLE      cycles discarded after start, before counting (0 = none)
//   CONTINUOUS  1 = re-arm automatically after each accepted result
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   x          stochastic bitstream, synchronous to clk
//   start      begins a conversion; sampled only while idle
//   busy       high while settling, counting or holding a result
//   out_valid  y holds a valid result; high only while holding
//   out_ready  consumer accepts y when out_valid & out_ready
//   y          ones count, saturated to 2**WIDTH-1
//
// All outputs are registered. There is no combinational path from any input
// to any output.

module bitstream_to_binary #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETTLE     = 16,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // SETTLE_LAST is unused when SETTLE == 0 because the settle state is never entered.
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
    localparam logic [WIDTH-1:0] WIN_LAST = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCount,
        StHold
    } state_e;

    // Entry state of a conversion: skip the settle state entirely when SETTLE is 0.
    localparam state_e ARM_STATE = (SETTLE > 0) ? StSettle : StCount;

    state_e           state_q;
    logic [SW-1:0]    settle_cnt_q;
    logic [WIDTH-1:0] win_cnt_q;
    // One extra bit so that an all-ones window (2**WIDTH) cannot overflow.
    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   acc_next;

    assign acc_next = acc_q + {{WIDTH{1'b0}}, x};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            y            <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= ARM_STATE;
                        settle_cnt_q <= '0;
                        win_cnt_q    <= '0;
                        acc_q        <= '0;
                        busy         <= 1'b1;
                    end
                end

                StSettle: begin
                    settle_cnt_q <= settle_cnt_q + 1'b1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= StCount;
                    end
                end

                StCount: begin
                    acc_q     <= acc_next;
                    win_cnt_q <= win_cnt_q + 1'b1;
                    // The last sample is folded in on the same edge that publishes y.
                    if (win_cnt_q == WIN_LAST) begin
                        state_q   <= StHold;
                        out_valid <= 1'b1;
                        y         <= acc_next[WIDTH] ? '1 : acc_next[WIDTH-1:0];
                    end
                end

                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (CONTINUOUS) begin
                            // The transfer edge acts as a fresh start edge.
                            state_q      <= ARM_STATE;
                            settle_cnt_q <= '0;
                            win_cnt_q    <= '0;
                            acc_q        <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
